shift_engine: RTL

SHIFT_ENGINE -- requirements
Module: shift_engine

---
 rtl/shift_engine_pkg.sv | 9 +
 rtl/shift_engine_datapath.sv | 44 ++++
 rtl/shift_engine.sv | 121 ++++++++++++
 3 files changed

// File: rtl/shift_engine_pkg.sv
// Shared types for the shift_engine block (FSM state encoding).
package shift_engine_pkg;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } shift_engine_state_e;

endpackage : shift_engine_pkg

// File: rtl/shift_engine_datapath.sv
// Shift register with parallel load, serial insert/extract and bit-order muxing.
module shift_engine_datapath #(
    parameter int unsigned      WIDTH     = 8,
    parameter logic [WIDTH-1:0] INIT      = '0,
    parameter bit               LSB_FIRST = 1'b0
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_load,
    input  logic [WIDTH-1:0] i_load_data,
    input  logic             i_shift,
    input  logic             i_sdata,
    output logic             o_sdata_c,
    output logic [WIDTH-1:0] o_next_c
);

    logic [WIDTH-1:0] sreg_q;

    // Outgoing end and post-shift value depend on bit order.
    generate
        if (LSB_FIRST) begin : g_lsb_first
            always_comb begin
                o_sdata_c = sreg_q[0];
                o_next_c  = {i_sdata, sreg_q[WIDTH-1:1]};
            end
        end else begin : g_msb_first
            always_comb begin
                o_sdata_c = sreg_q[WIDTH-1];
                o_next_c  = {sreg_q[WIDTH-2:0], i_sdata};
            end
        end
    endgenerate

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            sreg_q <= INIT;
        end else if (i_load) begin
            sreg_q <= i_load_data;
        end else if (i_shift) begin
            sreg_q <= o_next_c;
        end
    end

endmodule : shift_engine_datapath

// File: rtl/shift_engine.sv
// Serial shift engine: loads a word, shifts it out while shifting a new word in.
// Optional sticky overrun flag enabled by defining SHIFT_ENGINE_OVERRUN_EN.
module shift_engine
    import shift_engine_pkg::*;
#(
    parameter int unsigned      WIDTH     = 8,
    parameter logic [WIDTH-1:0] INIT      = '0,
    parameter bit               LSB_FIRST = 1'b0
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_load_valid,
    output logic             o_load_ready,
    input  logic [WIDTH-1:0] i_load_data,
    input  logic             i_shift,
    input  logic             i_sdata,
    output logic             o_sdata,
    output logic             o_busy,
    output logic [WIDTH-1:0] o_data,
`ifdef SHIFT_ENGINE_OVERRUN_EN
    input  logic             i_overrun_clr,
    output logic             o_overrun,
`endif
    output logic             o_data_valid
);

    localparam int unsigned      CNT_W    = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    shift_engine_state_e state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                load_c;
    logic                step_c;
    logic                done_c;
    logic [WIDTH-1:0]    next_c;

    shift_engine_datapath #(
        .WIDTH     (WIDTH),
        .INIT      (INIT),
        .LSB_FIRST (LSB_FIRST)
    ) u_datapath (
        .i_clk       (i_clk),
        .i_rst       (i_rst),
        .i_load      (load_c),
        .i_load_data (i_load_data),
        .i_shift     (step_c),
        .i_sdata     (i_sdata),
        .o_sdata_c   (o_sdata),
        .o_next_c    (next_c)
    );

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next state, counter update and datapath strobes.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        load_c  = 1'b0;
        step_c  = 1'b0;
        done_c  = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (i_load_valid) begin
                    load_c  = 1'b1;
                    cnt_d   = '0;
                    state_d = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                if (i_shift) begin
                    step_c = 1'b1;
                    if (cnt_q == CNT_LAST) begin
                        done_c  = 1'b1;
                        state_d = ST_IDLE;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign o_busy       = (state_q == ST_SHIFT);
    assign o_load_ready = (state_q == ST_IDLE);

    // Received word is captured on the final strobe; valid follows for one cycle.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            o_data       <= '0;
            o_data_valid <= 1'b0;
        end else begin
            o_data_valid <= done_c;
            if (done_c) begin
                o_data <= next_c;
            end
        end
    end

`ifdef SHIFT_ENGINE_OVERRUN_EN
    // Sticky: a word offered while busy is dropped; set beats clear.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            o_overrun <= 1'b0;
        end else if ((state_q == ST_SHIFT) && i_load_valid) begin
            o_overrun <= 1'b1;
        end else if (i_overrun_clr) begin
            o_overrun <= 1'b0;
        end
    end
`endif

endmodule : shift_engine
